// File: rtl/scalar_product_seq_ctrl_if.sv
// rtl/scalar_product_seq_ctrl_if.sv - start/done request bus between requester and dot-product controller
interface scalar_product_seq_ctrl_if #(
  parameter int SIZE_ARRAY = 4,
  parameter int SIZE_INT   = 32
);
  localparam int SIZE = SIZE_ARRAY * SIZE_INT;

  logic                start;
  logic [SIZE-1:0]     IX;
  logic [SIZE-1:0]     IY;
  logic                busy;
  logic                done;
  logic [SIZE_INT-1:0] result;

  modport master (
    output start, IX, IY,
    input  busy, done, result
  );

  modport slave (
    input  start, IX, IY,
    output busy, done, result
  );
endinterface

// File: rtl/scalar_product_seq_ctrl.sv
// rtl/scalar_product_seq_ctrl.sv - time-shared single-multiplier dot product controller (option: MULT_PIPE_EN)
module scalar_product_seq_ctrl #(
  parameter  int SIZE_ARRAY = 4,
  parameter  int SIZE_INT   = 32,
  localparam int SIZE       = SIZE_ARRAY * SIZE_INT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  scalar_product_seq_ctrl_if.slave bus
);

  localparam int IW = (SIZE_ARRAY > 1) ? $clog2(SIZE_ARRAY) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_ARRAY - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SIZE-1:0]     x_q, x_d;
  logic [SIZE-1:0]     y_q, y_d;
  logic [SIZE_INT-1:0] acc_q, acc_d;
  logic [SIZE_INT-1:0] result_q, result_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

`ifdef MULT_PIPE_EN
  logic [SIZE_INT-1:0] prod_q, prod_d;
  logic                drain_q, drain_d;
`endif

  // Operand elements as arrays so the single multiplier is a plain mux on idx.
  logic [SIZE_INT-1:0] x_el [SIZE_ARRAY];
  logic [SIZE_INT-1:0] y_el [SIZE_ARRAY];
  logic [SIZE_INT-1:0] prod;

  for (genvar k = 0; k < SIZE_ARRAY; k++) begin : g_unpack
    assign x_el[k] = x_q[k*SIZE_INT +: SIZE_INT];
    assign y_el[k] = y_q[k*SIZE_INT +: SIZE_INT];
  end

  // Product truncated to SIZE_INT bits by the assignment width.
  assign prod = x_el[idx_q] * y_el[idx_q];

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Next-state and datapath: latch operands on start, one MAC per edge, publish result at the end.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef MULT_PIPE_EN
    prod_d   = prod_q;
    drain_d  = drain_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = bus.IX;
          y_d     = bus.IY;
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
`ifdef MULT_PIPE_EN
          prod_d  = '0;
          drain_d = 1'b0;
`endif
        end
      end
      MAC: begin
`ifdef MULT_PIPE_EN
        // prod_q lags the multiplier by one edge; a final drain edge folds in the last product.
        acc_d = acc_q + prod_q;
        if (drain_q) begin
          result_d = acc_q + prod_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          drain_d  = 1'b0;
          state_d  = IDLE;
        end else begin
          prod_d = prod;
          if (idx_q == LAST_IDX) begin
            drain_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
`else
        acc_d = acc_q + prod;
        if (idx_q == LAST_IDX) begin
          result_d = acc_q + prod;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULT_PIPE_EN
      prod_q   <= '0;
      drain_q  <= 1'b0;
`endif
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULT_PIPE_EN
      prod_q   <= prod_d;
      drain_q  <= drain_d;
`endif
    end
  end

endmodule

// File: tb/tb_scalar_product_seq_ctrl.sv
// tb/tb_scalar_product_seq_ctrl.sv - scoreboard bench for scalar_product_seq_ctrl
module tb_scalar_product_seq_ctrl;
  localparam int N = 4;
  localparam int W = 32;
`ifdef MULT_PIPE_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scalar_product_seq_ctrl_if #(.SIZE_ARRAY(N), .SIZE_INT(W)) bus ();
  scalar_product_seq_ctrl #(.SIZE_ARRAY(N), .SIZE_INT(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           c0;
  } exp_t;
  exp_t sb[$];
  logic [W-1:0] last_result = '0;

  function automatic logic [W-1:0] dot(input logic [N*W-1:0] x, input logic [N*W-1:0] y);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < N; k++) s += 64'(x[k*W +: W]) * 64'(y[k*W +: W]);
    return s[W-1:0];
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", 64'(bus.result), 64'(e.res));
          check("latency", 64'(cyc - e.c0 + 1), 64'(LAT));
          check("busy_at_done", 64'(bus.busy), 64'd0);
          last_result = e.res;
        end
      end else begin
        if (sb.size() > 0 && cyc >= sb[0].c0) check("busy_during_op", 64'(bus.busy), 64'd1);
        check("result_stable", 64'(bus.result), 64'(last_result));
      end
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < LAT + 4) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      check("done_timeout", 64'(bus.done), 64'd1);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [N*W-1:0] x, input logic [N*W-1:0] y, input int hold, input int gap);
    exp_t e;
    repeat (gap) @(negedge clk);
    bus.IX = x;
    bus.IY = y;
    bus.start = 1'b1;
    e.res = dot(x, y);
    e.c0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    for (int i = 0; i < hold; i++) begin
      bus.IX = rand_vec();
      bus.IY = rand_vec();
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.IX = rand_vec();
    wait_done();
  endtask

  task automatic reset_mid_op(input logic [N*W-1:0] x, input logic [N*W-1:0] y);
    run_start_only(x, y);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    sb.delete();
    last_result = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
  endtask

  task automatic run_start_only(input logic [N*W-1:0] x, input logic [N*W-1:0] y);
    exp_t e;
    bus.IX = x;
    bus.IY = y;
    bus.start = 1'b1;
    e.res = dot(x, y);
    e.c0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [N*W-1:0] ones;
    logic [N*W-1:0] twos;
    logic [N*W-1:0] all_f;
    for (int k = 0; k < N; k++) begin
      ones[k*W +: W]  = W'(1);
      twos[k*W +: W]  = W'(2);
      all_f[k*W +: W] = {W{1'b1}};
    end
    bus.start = 1'b0;
    bus.IX = '0;
    bus.IY = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op({32'd4, 32'd3, 32'd2, 32'd1}, {32'd8, 32'd7, 32'd6, 32'd5}, 0, 0);
    run_op(all_f, twos, 0, 1);
    run_op(rand_vec(), rand_vec(), 3, 2);
    run_op(ones, ones, 0, 0);
    reset_mid_op(rand_vec(), rand_vec());
    run_op(rand_vec(), rand_vec(), 0, 0);
    run_op('0, rand_vec(), 0, 1);

    for (int i = 0; i < 30; i++)
      run_op(rand_vec(), rand_vec(), $urandom_range(0, N - 1), $urandom_range(0, 2));

    repeat (LAT + 2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
